alu_iter_unit: RTL

ALU_ITER_UNIT -- requirements
Module: alu_iter_unit

---
 rtl/alu_iter_unit.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_iter_unit.sv
// Iterative ALU: single-cycle logic/add/move/swap ops, shift-add multiplier and restoring divider.
// Define ALU_ITER_DIV_EN to build the divider; otherwise funct 0101 decodes as illegal.
module alu_iter_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             div_zero,
  output logic             illegal
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef ALU_ITER_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd3
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               out_valid_q, out_valid_d;
  logic               illegal_q, illegal_d;
  logic               last_iter;

  // Multiplier step: conditionally add multiplicand into the high half, then shift {carry,hi,lo} right.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_nxt;
  logic [WIDTH-1:0]   mul_lo_nxt;

  always_comb begin
    if (lo_q[0]) begin
      mul_sum = (WIDTH+1)'(hi_q) + (WIDTH+1)'(b_q);
    end else begin
      mul_sum = (WIDTH+1)'(hi_q);
    end
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

`ifdef ALU_ITER_DIV_EN
  // Restoring divider step: hi holds the partial remainder, lo shifts dividend out and quotient in.
  logic               div_zero_q, div_zero_d;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi_nxt;
  logic [WIDTH-1:0]   div_lo_nxt;

  always_comb begin
    div_sh = {hi_q, lo_q[WIDTH-1]};
    div_ge = (div_sh >= (WIDTH+1)'(b_q));
    if (div_ge) begin
      div_hi_nxt = div_sh[WIDTH-1:0] - b_q;
    end else begin
      div_hi_nxt = div_sh[WIDTH-1:0];
    end
    div_lo_nxt = {lo_q[WIDTH-2:0], div_ge};
  end

  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
`ifdef ALU_ITER_DIV_EN
      div_zero_q  <= div_zero_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    out_valid_d = out_valid_q;
    illegal_d   = illegal_q;
`ifdef ALU_ITER_DIV_EN
    div_zero_d  = div_zero_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Single-cycle ops are the common case; iterative ops override the target state.
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          result_d    = '0;
          result_hi_d = '0;
          unique case (alu_op)
            2'b00: result_d = op_a & op_b;
            2'b11: result_d = op_a | op_b;
            2'b10: result_d = op_a + op_b;
            2'b01: begin
              case (funct)
                4'b0000: result_d = op_a + op_b;
                4'b0001: result_d = op_a - op_b;
                4'b0100: begin
                  state_d     = S_MUL;
                  out_valid_d = 1'b0;
                  hi_d        = '0;
                  lo_d        = op_a;
                  b_d         = op_b;
                end
`ifdef ALU_ITER_DIV_EN
                4'b0101: begin
                  if (op_b == '0) begin
                    result_d    = '1;
                    result_hi_d = op_a;
                    div_zero_d  = 1'b1;
                  end else begin
                    state_d     = S_DIV;
                    out_valid_d = 1'b0;
                    hi_d        = '0;
                    lo_d        = op_a;
                    b_d         = op_b;
                  end
                end
`endif
                4'b0111: result_d = op_b;
                4'b1000: begin
                  result_d    = op_b;
                  result_hi_d = op_a;
                end
                default: illegal_d = 1'b1;
              endcase
            end
          endcase
        end
      end

      S_MUL: begin
        hi_d  = mul_hi_nxt;
        lo_d  = mul_lo_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          result_d    = mul_lo_nxt;
          result_hi_d = mul_hi_nxt;
        end
      end

`ifdef ALU_ITER_DIV_EN
      S_DIV: begin
        hi_d  = div_hi_nxt;
        lo_d  = div_lo_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          result_d    = div_lo_nxt;
          result_hi_d = div_hi_nxt;
        end
      end
`endif

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          illegal_d   = 1'b0;
`ifdef ALU_ITER_DIV_EN
          div_zero_d  = 1'b0;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign illegal   = illegal_q;

endmodule
